// File: rtl/sponge_arbiter_if.sv
// Requester and core-side signal bundle for sponge_arbiter.
// The arbiter takes the slave modport; requesters and the core model take master.
interface sponge_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IN_W  = 256,
    parameter int unsigned LEN_W = 14,
    parameter int unsigned OUT_W = 5376
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*IN_W-1:0]  req_in;
    logic [NREQ*4-1:0]     req_domain;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [OUT_W-1:0]      rsp_data;
    logic                  rsp_err;
    logic                  core_rst;
    logic                  core_enable;
    logic [IN_W-1:0]       core_in;
    logic [3:0]            core_domain;
    logic [LEN_W-1:0]      core_len;
    logic [OUT_W-1:0]      core_out;
    logic                  core_done;

    modport slave (
        input  req_valid, req_in, req_domain, req_len, rsp_ready, core_out, core_done,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output core_rst, core_enable, core_in, core_domain, core_len
    );

    modport master (
        output req_valid, req_in, req_domain, req_len, rsp_ready, core_out, core_done,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  core_rst, core_enable, core_in, core_domain, core_len
    );
endinterface

// File: rtl/sponge_arbiter.sv
// Round-robin arbiter and job sequencer sharing one sponge Keccak core among NREQ requesters.
// One job in flight: grant, load, settle, run (with watchdog), respond.
module sponge_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IN_W    = 256,
    parameter int unsigned LEN_W   = 14,
    parameter int unsigned OUT_W   = 5376,
    parameter int unsigned TIMEOUT = 1023,
    localparam int unsigned IdW    = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    sponge_arbiter_if.slave bus,
    output logic            busy,
    output logic [IdW-1:0]  grant_id
);
    localparam int unsigned WdogW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StLoad, StSettle, StRun, StResp} state_e;

    state_e               state_q, state_d;
    logic [IdW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]       grant_id_q, grant_id_d;
    logic [IN_W-1:0]      job_in_q, job_in_d;
    logic [3:0]           job_dom_q, job_dom_d;
    logic [LEN_W-1:0]     job_len_q, job_len_d;
    logic [WdogW-1:0]     wdog_q, wdog_d;
    logic [OUT_W-1:0]     rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [NREQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic                 core_rst_q, core_rst_d;
    logic                 core_en_q, core_en_d;
    logic                 busy_q, busy_d;
    logic [NREQ-1:0]      req_ready;
    logic [IdW-1:0]       gnt_idx;
    logic                 len_bad;

    // First asserted requester at or after ptr, wrapping.
    function automatic logic [IdW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                               input logic [IdW-1:0]  ptr);
        logic [IdW-1:0] pick;
        logic           found;
        int unsigned    j;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = (32'(ptr) + k) % NREQ;
            if (!found && v[IdW'(j)]) begin
                pick  = IdW'(j);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign gnt_idx = rr_pick(bus.req_valid, rr_ptr_q);
    assign len_bad = (job_len_q == '0) || (32'(job_len_q) > OUT_W) || (job_len_q[2:0] != 3'd0);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        job_in_d   = job_in_q;
        job_dom_d  = job_dom_q;
        job_len_d  = job_len_q;
        wdog_d     = wdog_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        req_ready  = '0;

        unique case (state_q)
            StIdle: begin
                if (|bus.req_valid) begin
                    req_ready  = NREQ'(1) << gnt_idx;
                    job_in_d   = bus.req_in[gnt_idx*IN_W +: IN_W];
                    job_dom_d  = bus.req_domain[gnt_idx*4 +: 4];
                    job_len_d  = bus.req_len[gnt_idx*LEN_W +: LEN_W];
                    grant_id_d = gnt_idx;
                    rr_ptr_d   = (gnt_idx == IdW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                if (len_bad) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '0;
                    state_d    = StResp;
                end else begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                wdog_d  = '0;
                state_d = StRun;
            end
            StRun: begin
                if (bus.core_done) begin
                    rsp_data_d = bus.core_out;
                    rsp_err_d  = 1'b0;
                    state_d    = StResp;
                end else if (wdog_q == WdogW'(TIMEOUT - 1)) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = StResp;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            StResp: begin
                if (bus.rsp_ready[grant_id_q]) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered as a function of the state being entered.
        core_rst_d  = !((state_d == StSettle) || (state_d == StRun));
        core_en_d   = (state_d == StRun);
        busy_d      = (state_d != StIdle);
        rsp_valid_d = (state_d == StResp) ? (NREQ'(1) << grant_id_d) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            job_in_q    <= '0;
            job_dom_q   <= '0;
            job_len_q   <= '0;
            wdog_q      <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= '0;
            core_rst_q  <= 1'b1;
            core_en_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            job_in_q    <= job_in_d;
            job_dom_q   <= job_dom_d;
            job_len_q   <= job_len_d;
            wdog_q      <= wdog_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            core_rst_q  <= core_rst_d;
            core_en_q   <= core_en_d;
            busy_q      <= busy_d;
        end
    end

    // Ready is combinational off the idle state, so hold it low while reset is asserted.
    assign bus.req_ready   = rst ? req_ready : '0;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.core_rst    = core_rst_q;
    assign bus.core_enable = core_en_q;
    assign bus.core_in     = job_in_q;
    assign bus.core_domain = job_dom_q;
    assign bus.core_len    = job_len_q;
    assign busy            = busy_q;
    assign grant_id        = grant_id_q;
endmodule

// File: tb/tb_sponge_arbiter.sv
// Self-checking bench for sponge_arbiter: stub core, directed table, random jobs vs a
// round-robin reference model, watchdog and mid-run reset sequences.
module tb_sponge_arbiter;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned IN_W    = 256;
    localparam int unsigned LEN_W   = 14;
    localparam int unsigned OUT_W   = 5376;
    localparam int unsigned TIMEOUT = 1023;
    localparam int unsigned IdW     = $clog2(NREQ);
    localparam int          RunLat  = 28;

    logic           clk;
    logic           rst;
    logic           busy;
    logic [IdW-1:0] grant_id;

    sponge_arbiter_if #(.NREQ(NREQ), .IN_W(IN_W), .LEN_W(LEN_W), .OUT_W(OUT_W)) bus ();

    sponge_arbiter #(
        .NREQ(NREQ), .IN_W(IN_W), .LEN_W(LEN_W), .OUT_W(OUT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int model_rr = 0;

    logic [IN_W-1:0] seed [NREQ];
    logic [3:0]      dom  [NREQ];
    int              len  [NREQ];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub core: done 24 cycles after enable rises unless told to hang.
    int stub_cnt;
    bit stub_hang;
    always @(posedge clk) begin
        if (bus.core_rst || !bus.core_enable) stub_cnt <= 0;
        else if (stub_cnt < 100000)           stub_cnt <= stub_cnt + 1;
    end

    function automatic logic [OUT_W-1:0] stub_fn(input logic [IN_W-1:0] s, input logic [3:0] d,
                                                 input logic [LEN_W-1:0] l);
        logic [OUT_W-1:0] r;
        logic [IN_W-1:0]  x;
        x = s;
        r = '0;
        for (int i = 0; i < int'(OUT_W / IN_W); i++) begin
            x = ({x[IN_W-2:0], x[IN_W-1]} ^ IN_W'({d, l, 8'(i)})) + IN_W'(32'h9e3779b9);
            r[i*IN_W +: IN_W] = x;
        end
        return r;
    endfunction

    assign bus.core_out  = stub_fn(bus.core_in, bus.core_domain, bus.core_len);
    assign bus.core_done = bus.core_enable && !bus.core_rst && !stub_hang && (stub_cnt == 24);

    function automatic int model_pick(input logic [NREQ-1:0] m, input int rr);
        for (int k = 0; k < int'(NREQ); k++)
            if (m[IdW'((rr + k) % NREQ)]) return (rr + k) % NREQ;
        return -1;
    endfunction

    function automatic bit model_bad_len(input int l);
        return (l == 0) || (l > int'(OUT_W)) || (l % 8 != 0);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_data(input string name, input logic [OUT_W-1:0] act,
                              input logic [OUT_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: low 64 bits got %0h, expected %0h", name, act[63:0], exp[63:0]);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_ops();
        for (int i = 0; i < int'(NREQ); i++) begin
            bus.req_in[i*IN_W +: IN_W]     = seed[i];
            bus.req_domain[i*4 +: 4]       = dom[i];
            bus.req_len[i*LEN_W +: LEN_W]  = LEN_W'(len[i]);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "/busy_rst_en_err"}, {busy, bus.core_rst, bus.core_enable, bus.rsp_err},
              4'b0100);
        check({tag, "/grant_id"}, grant_id, 0);
        check({tag, "/rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "/req_ready"}, bus.req_ready, 0);
        check({tag, "/core_dom_len"}, {bus.core_domain, bus.core_len}, 0);
        check_data({tag, "/core_in"}, OUT_W'(bus.core_in), '0);
        check_data({tag, "/rsp_data"}, bus.rsp_data, '0);
    endtask

    // One complete job: present mask, expect grant exp_g, follow it to the response handshake.
    task automatic do_job(input logic [NREQ-1:0] mask, input int exp_g, input bit exp_run,
                          input bit exp_err, input int exp_lat, input int dly, input string tag);
        logic [NREQ-1:0]  g_oh;
        logic [OUT_W-1:0] exp_data;
        logic [OUT_W-1:0] hold_data;
        logic             hold_err;
        int n, lat, bad_busy, extra_rdy, bad_hold;
        bit saw_en, got;
        g_oh     = NREQ'(1) << exp_g;
        exp_data = exp_err ? '0 : stub_fn(seed[exp_g], dom[exp_g], LEN_W'(len[exp_g]));
        drive_ops();
        bus.req_valid = mask;
        #1;
        n = 0;
        while (bus.req_ready == '0 && n < 8) begin
            cyc();
            #1;
            n++;
        end
        check({tag, "/grant_wait"}, n, 0);
        check({tag, "/req_ready"}, bus.req_ready, g_oh);
        if (bus.req_ready != '0) begin
            lat = 0; got = 0; saw_en = 0; bad_busy = 0; extra_rdy = 0;
            while (!got && lat < int'(TIMEOUT) + 40) begin
                cyc();
                lat++;
                bus.rsp_ready = NREQ'($urandom) & ~g_oh;
                #1;
                if (lat == 1) begin
                    check({tag, "/grant_id"}, grant_id, exp_g);
                    check_data({tag, "/core_in"}, OUT_W'(bus.core_in), OUT_W'(seed[exp_g]));
                    check({tag, "/core_dom_len"}, {bus.core_domain, bus.core_len},
                          {dom[exp_g], LEN_W'(len[exp_g])});
                    check({tag, "/load_rst_en"}, {bus.core_rst, bus.core_enable}, 2'b10);
                end
                if (exp_run && lat == 2)
                    check({tag, "/settle_rst_en"}, {bus.core_rst, bus.core_enable}, 2'b00);
                if (exp_run && lat == 3)
                    check({tag, "/run_rst_en"}, {bus.core_rst, bus.core_enable}, 2'b01);
                saw_en |= bus.core_enable;
                if (!busy) bad_busy++;
                if (bus.req_ready != '0) extra_rdy++;
                got = (bus.rsp_valid != '0);
            end
            check({tag, "/rsp_arrived"}, got, 1);
            if (exp_lat >= 0) check({tag, "/latency"}, lat, exp_lat);
            if (!exp_run) check({tag, "/core_enable_seen"}, saw_en, 0);
            check({tag, "/rsp_valid"}, bus.rsp_valid, g_oh);
            check({tag, "/rsp_err"}, bus.rsp_err, exp_err);
            check_data({tag, "/rsp_data"}, bus.rsp_data, exp_data);
            check({tag, "/resp_rst_en"}, {bus.core_rst, bus.core_enable}, 2'b10);
            hold_data = bus.rsp_data;
            hold_err  = bus.rsp_err;
            bad_hold  = 0;
            repeat (dly) begin
                cyc();
                bus.rsp_ready = NREQ'($urandom) & ~g_oh;
                #1;
                if (bus.rsp_valid != g_oh || bus.rsp_data != hold_data || bus.rsp_err != hold_err)
                    bad_hold++;
                if (!busy) bad_busy++;
                if (bus.req_ready != '0) extra_rdy++;
            end
            check({tag, "/rsp_stable"}, bad_hold, 0);
            check({tag, "/busy_low_in_job"}, bad_busy, 0);
            check({tag, "/ready_while_busy"}, extra_rdy, 0);
            bus.rsp_ready = g_oh | (NREQ'($urandom));
            cyc();
            bus.rsp_ready = '0;
            #1;
            check({tag, "/after_hs_valid_busy"}, {bus.rsp_valid, busy}, 0);
        end
        model_rr = (exp_g + 1) % NREQ;
    endtask

    typedef struct {
        logic [NREQ-1:0] mask;
        int              len;
        int              exp_g;
        bit              exp_err;
        int              dly;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g;
        bit err;
        logic [NREQ-1:0] m;
        rst           = 1'b0;
        stub_hang     = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            seed[i] = IN_W'(i + 1) * IN_W'(64'h0123456789abcdef);
            dom[i]  = 4'(i + 3);
            len[i]  = 256;
        end
        drive_ops();

        repeat (3) cyc();
        check_reset("por");
        rst = 1'b1;

        // Single request on port 1.
        seed[1] = 256'hf8f11229_3b5e7a10_0c4d9e2f_a1b2c3d4_5e6f7081_92a3b4c5_d6e7f809_c9665598;
        dom[1]  = 4'hF;
        len[1]  = 1024;
        do_job(4'b0010, 1, 1, 0, RunLat, 0, "single");

        // Directed table, requests held high from reset.
        tbl[0] = '{4'b1111, 512,  0, 1'b0, 0};
        tbl[1] = '{4'b1111, 512,  1, 1'b0, 0};
        tbl[2] = '{4'b1111, 256,  2, 1'b0, 5};
        tbl[3] = '{4'b1111, 256,  3, 1'b0, 0};
        tbl[4] = '{4'b1111, 8,    0, 1'b0, 1};
        tbl[5] = '{4'b0100, 0,    2, 1'b1, 0};
        tbl[6] = '{4'b1100, 5384, 3, 1'b1, 2};
        tbl[7] = '{4'b0101, 1001, 0, 1'b1, 0};
        tbl[8] = '{4'b0101, 5376, 2, 1'b0, 0};
        tbl[9] = '{4'b0011, 8,    0, 1'b0, 3};
        bus.req_valid = 4'b1111;
        rst = 1'b0;
        repeat (2) cyc();
        check_reset("rst_hold_valid");
        rst = 1'b1;
        model_rr = 0;
        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < int'(NREQ); i++) len[i] = tbl[v].len;
            do_job(tbl[v].mask, tbl[v].exp_g, !tbl[v].exp_err, tbl[v].exp_err,
                   tbl[v].exp_err ? -1 : RunLat, tbl[v].dly, $sformatf("tbl%0d", v));
        end

        // Hung core: watchdog error, then a clean job.
        len[1]    = 1024;
        stub_hang = 1'b1;
        g = model_pick(4'b0010, model_rr);
        do_job(4'b0010, g, 1, 1, 3 + int'(TIMEOUT), 0, "hang");
        stub_hang = 1'b0;
        g = model_pick(4'b0010, model_rr);
        do_job(4'b0010, g, 1, 0, RunLat, 0, "after_hang");

        // Random traffic against the round-robin model.
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                for (int w = 0; w < int'(IN_W / 32); w++) seed[i][w*32 +: 32] = $urandom;
                dom[i] = 4'($urandom);
                case ($urandom_range(0, 6))
                    0:       len[i] = 0;
                    1:       len[i] = 5384;
                    2:       len[i] = 1001;
                    3:       len[i] = int'(OUT_W);
                    default: len[i] = 8 * int'($urandom_range(1, OUT_W / 8));
                endcase
            end
            m   = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            g   = model_pick(m, model_rr);
            err = model_bad_len(len[g]);
            do_job(m, g, !err, err, err ? -1 : RunLat, int'($urandom_range(0, 3)),
                   $sformatf("rnd%0d", t));
        end

        // Reset in the middle of RUN on port 3.
        len[3] = 2048;
        drive_ops();
        bus.req_valid = 4'b1000;
        #1;
        check("midrun/req_ready", bus.req_ready, 4'b1000);
        repeat (6) cyc();
        check("midrun/in_run", {busy, bus.core_enable}, 2'b11);
        #1;
        rst = 1'b0;
        #1;
        check_reset("midrun_async");
        repeat (2) cyc();
        check_reset("midrun_held");
        bus.req_valid = '0;
        rst = 1'b1;
        model_rr = 0;
        len[2] = 1024;
        do_job(4'b0100, 2, 1, 0, RunLat, 1, "post_rst");
        len[0] = 64;
        g = model_pick(4'b0101, model_rr);
        do_job(4'b0101, g, 1, 0, RunLat, 0, "post_rst_rr");
        bus.req_valid = '0;
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
